// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB initiator
package apb_pkg;

   // Low address bits that must be zero for a word-aligned access.
   localparam int APB_ALIGN_BITS = 2;

   // Width of the data field carried in a buffered response.
   localparam int APB_RSP_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_master_state_e;

   typedef struct packed {
      logic [APB_RSP_DATA_W-1:0] rdata;
      logic                      err;
      logic                      timeout;
   } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - saturating ACCESS-phase wait counter with expire flag
module apb_timeout_cnt #(
   parameter int unsigned LIMIT = 256,
   parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [CNT_W-1:0] SAT  = CNT_W'(LIMIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Count waited cycles; stop at LIMIT so a long stall can never wrap back to zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != SAT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The cycle being waited now is the last one allowed.
   assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - valid/ready request to APB3 initiator with timeout and response buffer
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                      clk,
   input  logic                      rst_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic                      req_write_i,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
   input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      rsp_timeout_o,
   output logic [APB_ADDR_WIDTH-1:0] PADDR,
   output logic [APB_DATA_WIDTH-1:0] PWDATA,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   input  logic [APB_DATA_WIDTH-1:0] PRDATA,
   input  logic                      PREADY,
   input  logic                      PSLVERR
);

   apb_master_state_e         state_q, state_d;
   logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                      pwrite_q, pwrite_d;
   apb_rsp_t                  rsp_q, rsp_d;

   logic cnt_clr;
   logic cnt_en;
   logic cnt_expire;

   // Wait counter exists only when a timeout is configured.
   generate
      if (TIMEOUT_CYCLES != 0) begin : g_timeout
         apb_timeout_cnt #(
            .LIMIT (TIMEOUT_CYCLES)
         ) u_timeout_cnt (
            .clk      (clk),
            .rst_i    (rst_i),
            .clr_i    (cnt_clr),
            .en_i     (cnt_en),
            .expire_o (cnt_expire)
         );
      end else begin : g_no_timeout
         assign cnt_expire = 1'b0;
      end
   endgenerate

   // Next-state and datapath: one transfer in flight, response parked until consumed.
   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      pwrite_d = pwrite_q;
      rsp_d    = rsp_q;
      cnt_en   = (state_q == ACCESS) && !PREADY;
      cnt_clr  = (state_q == RESP) && rsp_ready_i;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               if (req_addr_i[APB_ALIGN_BITS-1:0] != '0) begin
                  // Misaligned: answer immediately without touching the bus.
                  rsp_d   = '{rdata: '0, err: 1'b1, timeout: 1'b0};
                  state_d = RESP;
               end else begin
                  paddr_d  = req_addr_i;
                  pwdata_d = req_wdata_i;
                  pwrite_d = req_write_i;
                  state_d  = SETUP;
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            // PREADY is tested first so a completion on the last allowed cycle is not a timeout.
            if (PREADY) begin
               rsp_d.rdata   = (!pwrite_q && !PSLVERR) ? APB_RSP_DATA_W'(PRDATA) : '0;
               rsp_d.err     = PSLVERR;
               rsp_d.timeout = 1'b0;
               state_d       = RESP;
            end else if (cnt_expire) begin
               rsp_d   = '{rdata: '0, err: 1'b1, timeout: 1'b1};
               state_d = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, bus and response registers; reset abandons any transfer in flight.
   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q  <= IDLE;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
         rsp_q    <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         pwrite_q <= pwrite_d;
         rsp_q    <= rsp_d;
      end
   end

   assign req_ready_o   = (state_q == IDLE);
   assign rsp_valid_o   = (state_q == RESP);
   assign rsp_rdata_o   = APB_DATA_WIDTH'(rsp_q.rdata);
   assign rsp_err_o     = rsp_q.err;
   assign rsp_timeout_o = rsp_q.timeout;
   assign PSEL          = (state_q == SETUP) || (state_q == ACCESS);
   assign PENABLE       = (state_q == ACCESS);
   assign PADDR         = paddr_q;
   assign PWDATA        = pwdata_q;
   assign PWRITE        = pwrite_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master
module tb_apb_master;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic          req_write_i = 1'b0;
   logic [AW-1:0] req_addr_i = '0;
   logic [DW-1:0] req_wdata_i = '0;
   logic          rsp_valid_o;
   logic          rsp_ready_i = 1'b1;
   logic [DW-1:0] rsp_rdata_o;
   logic          rsp_err_o;
   logic          rsp_timeout_o;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA;
   logic          PWRITE;
   logic          PSEL;
   logic          PENABLE;
   logic [DW-1:0] PRDATA = '0;
   logic          PREADY = 1'b0;
   logic          PSLVERR = 1'b0;

   always #5 clk = ~clk;

   apb_master #(
      .APB_DATA_WIDTH (DW),
      .APB_ADDR_WIDTH (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .rst_i         (rst_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_write_i   (req_write_i),
      .req_addr_i    (req_addr_i),
      .req_wdata_i   (req_wdata_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_rdata_o   (rsp_rdata_o),
      .rsp_err_o     (rsp_err_o),
      .rsp_timeout_o (rsp_timeout_o),
      .PADDR         (PADDR),
      .PWDATA        (PWDATA),
      .PWRITE        (PWRITE),
      .PSEL          (PSEL),
      .PENABLE       (PENABLE),
      .PRDATA        (PRDATA),
      .PREADY        (PREADY),
      .PSLVERR       (PSLVERR)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave: wait s_wait ACCESS cycles, then complete; s_hang never completes.
   int            s_wait  = 0;
   bit            s_hang  = 1'b0;
   bit            s_err   = 1'b0;
   logic [DW-1:0] s_rdata = '0;
   int            s_acc   = 0;

   always @(negedge clk) begin
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
         if (!s_hang && s_acc >= s_wait) begin
            PREADY  = 1'b1;
            PRDATA  = s_rdata;
            PSLVERR = s_err;
         end else begin
            PREADY  = 1'b0;
            PRDATA  = 32'hBAD0_BAD0;
            PSLVERR = 1'b0;
         end
         s_acc = s_acc + 1;
      end else begin
         PREADY  = 1'b0;
         PRDATA  = 32'hBAD0_BAD0;
         PSLVERR = 1'b0;
         s_acc   = 0;
      end
   end

   // Transaction-level model: "busy on the bus for N cycles", "a response is waiting".
   bit            m_bus   = 1'b0;
   int            m_age   = 0;
   bit            m_rsp_v = 1'b0;
   logic [DW-1:0] m_rdata = '0;
   bit            m_err   = 1'b0;
   bit            m_to    = 1'b0;
   logic [AW-1:0] m_addr  = '0;
   logic [DW-1:0] m_wdata = '0;
   bit            m_write = 1'b0;

   always @(posedge clk) begin
      if (rst_i) begin
         m_bus   <= 1'b0;
         m_age   <= 0;
         m_rsp_v <= 1'b0;
         m_rdata <= '0;
         m_err   <= 1'b0;
         m_to    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         m_write <= 1'b0;
      end else if (m_rsp_v) begin
         if (rsp_ready_i) m_rsp_v <= 1'b0;
      end else if (m_bus) begin
         if (m_age == 1) begin
            m_age <= 2;
         end else if (PREADY) begin
            m_bus   <= 1'b0;
            m_rsp_v <= 1'b1;
            m_err   <= PSLVERR;
            m_to    <= 1'b0;
            m_rdata <= (m_write || PSLVERR) ? '0 : PRDATA;
         end else if (TO != 0 && (m_age - 1) == TO) begin
            m_bus   <= 1'b0;
            m_rsp_v <= 1'b1;
            m_err   <= 1'b1;
            m_to    <= 1'b1;
            m_rdata <= '0;
         end else begin
            m_age <= m_age + 1;
         end
      end else if (req_valid_i) begin
         if (req_addr_i % 4 != 0) begin
            m_rsp_v <= 1'b1;
            m_err   <= 1'b1;
            m_to    <= 1'b0;
            m_rdata <= '0;
         end else begin
            m_bus   <= 1'b1;
            m_age   <= 1;
            m_addr  <= req_addr_i;
            m_wdata <= req_wdata_i;
            m_write <= req_write_i;
         end
      end
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("req_ready", req_ready_o, !m_bus && !m_rsp_v);
         chk("rsp_valid", rsp_valid_o, m_rsp_v);
         chk("psel", PSEL, m_bus);
         chk("penable", PENABLE, m_bus && m_age >= 2);
         chk("paddr", PADDR, m_addr);
         chk("pwdata", PWDATA, m_wdata);
         chk("pwrite", PWRITE, m_write);
         if (m_rsp_v) begin
            chk("rsp_rdata", rsp_rdata_o, m_rdata);
            chk("rsp_err", rsp_err_o, m_err);
            chk("rsp_timeout", rsp_timeout_o, m_to);
         end
      end
   end

   // Present a request and return just after the edge that accepts it.
   task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit got;
      got = 1'b0;
      req_valid_i = 1'b1;
      req_write_i = w;
      req_addr_i  = a;
      req_wdata_i = d;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (req_ready_o === 1'b1) got = 1'b1;
      end
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      req_addr_i  = 32'hFFFF_FFF1;
      req_wdata_i = 32'h0F0F_0F0F;
      if (!got) chk("accept_bound", 64'd0, 64'd1);
   endtask

   // Return at the first negedge with rsp_valid_o high, counting ACCESS cycles seen.
   task automatic wait_rsp(output int acc);
      bit seen;
      seen = 1'b0;
      acc  = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (rsp_valid_o === 1'b1) seen = 1'b1;
         else if (PENABLE === 1'b1) acc++;
      end
      if (!seen) chk("rsp_bound", 64'd0, 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      repeat (3) @(posedge clk);
      #1;
      rst_i = 1'b0;
      cmp_en = 1'b1;

      // Reset values
      @(negedge clk);
      chk("rst_req_ready", req_ready_o, 1'b1);
      chk("rst_rsp_valid", rsp_valid_o, 1'b0);
      chk("rst_rsp_err", rsp_err_o, 1'b0);
      chk("rst_rsp_timeout", rsp_timeout_o, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
      chk("rst_psel", PSEL, 1'b0);
      chk("rst_paddr", PADDR, 32'h0);
      @(posedge clk);
      #1;

      // Zero-wait write: SETUP at 1, ACCESS at 2, response at 3, ready again at 4
      s_wait = 0;
      issue(1'b1, 32'h0000_0404, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("wr_c1_psel", PSEL, 1'b1);
      chk("wr_c1_penable", PENABLE, 1'b0);
      chk("wr_c1_paddr", PADDR, 32'h0000_0404);
      chk("wr_c1_pwdata", PWDATA, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("wr_c2_penable", PENABLE, 1'b1);
      chk("wr_c2_pwrite", PWRITE, 1'b1);
      chk("wr_c2_paddr", PADDR, 32'h0000_0404);
      @(negedge clk);
      chk("wr_c3_rsp_valid", rsp_valid_o, 1'b1);
      chk("wr_c3_err", rsp_err_o, 1'b0);
      chk("wr_c3_rdata", rsp_rdata_o, 32'h0);
      @(negedge clk);
      chk("wr_c4_req_ready", req_ready_o, 1'b1);
      chk("wr_c4_psel", PSEL, 1'b0);
      @(posedge clk);
      #1;

      // Read with 3 wait states
      s_wait = 3;
      s_rdata = 32'h1234_5678;
      issue(1'b0, 32'h0000_0008, 32'h0);
      wait_rsp(acc);
      chk("rd_access_cycles", acc, 4);
      chk("rd_rdata", rsp_rdata_o, 32'h1234_5678);
      chk("rd_err", rsp_err_o, 1'b0);
      chk("rd_psel_low", PSEL, 1'b0);
      chk("rd_penable_low", PENABLE, 1'b0);
      @(posedge clk);
      #1;

      // Read completing with PSLVERR
      s_wait = 1;
      s_err = 1'b1;
      s_rdata = 32'hCAFE_F00D;
      issue(1'b0, 32'h0000_0010, 32'h0);
      wait_rsp(acc);
      chk("slverr_err", rsp_err_o, 1'b1);
      chk("slverr_timeout", rsp_timeout_o, 1'b0);
      chk("slverr_rdata", rsp_rdata_o, 32'h0);
      s_err = 1'b0;
      @(posedge clk);
      #1;

      // Misaligned request never reaches the bus
      issue(1'b0, 32'h0000_0002, 32'h0);
      @(negedge clk);
      chk("mis_rsp_valid", rsp_valid_o, 1'b1);
      chk("mis_err", rsp_err_o, 1'b1);
      chk("mis_timeout", rsp_timeout_o, 1'b0);
      chk("mis_psel", PSEL, 1'b0);
      @(posedge clk);
      #1;

      // Timeout after 4 ACCESS cycles
      s_hang = 1'b1;
      issue(1'b0, 32'h0000_0020, 32'h0);
      wait_rsp(acc);
      chk("to_access_cycles", acc, 4);
      chk("to_err", rsp_err_o, 1'b1);
      chk("to_timeout", rsp_timeout_o, 1'b1);
      chk("to_rdata", rsp_rdata_o, 32'h0);
      s_hang = 1'b0;
      @(posedge clk);
      #1;

      // PREADY on the 4th ACCESS cycle beats the timeout
      s_wait = 3;
      issue(1'b1, 32'h0000_0024, 32'h0000_0055);
      wait_rsp(acc);
      chk("race_access_cycles", acc, 4);
      chk("race_err", rsp_err_o, 1'b0);
      chk("race_timeout", rsp_timeout_o, 1'b0);
      @(posedge clk);
      #1;

      // Response backpressure with a second request already waiting
      s_wait = 0;
      s_rdata = 32'hA5A5_A5A5;
      rsp_ready_i = 1'b0;
      issue(1'b0, 32'h0000_0030, 32'h0);
      wait_rsp(acc);
      req_valid_i = 1'b1;
      req_write_i = 1'b0;
      req_addr_i  = 32'h0000_0034;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid_o, 1'b1);
         chk("bp_rdata", rsp_rdata_o, 32'hA5A5_A5A5);
         chk("bp_req_ready", req_ready_o, 1'b0);
      end
      rsp_ready_i = 1'b1;
      @(negedge clk);
      chk("bp_after_hs_ready", req_ready_o, 1'b1);
      chk("bp_after_hs_psel", PSEL, 1'b0);
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      @(negedge clk);
      chk("bp_next_psel", PSEL, 1'b1);
      chk("bp_next_paddr", PADDR, 32'h0000_0034);
      wait_rsp(acc);
      @(posedge clk);
      #1;

      // Reset during ACCESS aborts the transfer
      s_hang = 1'b1;
      issue(1'b1, 32'h0000_0040, 32'h0000_0077);
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_in_access", PENABLE, 1'b1);
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      s_hang = 1'b0;
      @(negedge clk);
      chk("rst_mid_psel", PSEL, 1'b0);
      chk("rst_mid_penable", PENABLE, 1'b0);
      chk("rst_mid_rsp_valid", rsp_valid_o, 1'b0);
      chk("rst_mid_req_ready", req_ready_o, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk("rst_mid_no_rsp", rsp_valid_o, 1'b0);
      end
      @(posedge clk);
      #1;

      // Normal operation after reset
      s_wait = 0;
      s_rdata = 32'h0BAD_CAFE;
      issue(1'b0, 32'h0000_0044, 32'h0);
      wait_rsp(acc);
      chk("post_rst_rdata", rsp_rdata_o, 32'h0BAD_CAFE);
      @(posedge clk);
      #1;

      repeat (2) @(posedge clk);
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- Initiator end of the on-chip APB: converts a simple valid/ready request/response interface (from a core, debug module or DMA) into APB3 SETUP/ACCESS transfers.
- Drives a single PSEL into the APB interconnect, which decodes slave select from PADDR.
- Adds misalignment rejection, a bounded-wait timeout, and a one-entry response buffer with backpressure.

Parameters:
- APB_DATA_WIDTH, 32, width of PWDATA/PRDATA and request/response data.
- APB_ADDR_WIDTH, 32, width of PADDR and request address.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles to wait for PREADY; 0 disables the timeout.

Ports:
- clk  in  1  single clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid && ready.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  APB_ADDR_WIDTH  byte address.
- req_wdata_i  in  APB_DATA_WIDTH  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid && ready.
- rsp_rdata_o  out  APB_DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err_o  out  1  PSLVERR, misalignment or timeout.
- rsp_timeout_o  out  1  error cause was timeout.
- PADDR  out  APB_ADDR_WIDTH  APB address.
- PWDATA  out  APB_DATA_WIDTH  APB write data.
- PWRITE  out  1  APB direction.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PRDATA  in  APB_DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset values (next edge after rst_i=1, from any state): state IDLE; req_ready_o=1; rsp_valid_o=0; rsp_err_o=0; rsp_timeout_o=0; rsp_rdata_o=0; PSEL=0; PENABLE=0; PADDR=0; PWDATA=0; PWRITE=0; timeout counter=0.
- Reset mid-transfer aborts the transfer: no response is produced, and PSEL/PENABLE are low on the cycle after the reset edge.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o=1.
  - On accept with req_addr_i[1:0]!=0: go to RESP with rsp_err_o=1, rsp_timeout_o=0, rdata 0. No bus cycle is issued.
  - On any other accept: register addr, wdata and write into PADDR/PWDATA/PWRITE, then go to SETUP.
- SETUP: PSEL=1, PENABLE=0; exactly one cycle, then ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1. The counter increments each ACCESS cycle in which PREADY=0.
  - PREADY=1: sample PRDATA (reads only) and PSLVERR; rsp_err_o=PSLVERR; go to RESP. PSEL/PENABLE drop on the next cycle.
  - On a PSLVERR read, rsp_rdata_o=0.
  - PREADY=0 with counter==TIMEOUT_CYCLES-1 and TIMEOUT_CYCLES!=0: abort, rsp_err_o=1, rsp_timeout_o=1, go to RESP.
  - If PREADY=1 arrives on the same cycle the timeout would fire, PREADY wins (normal completion).
- RESP:
  - rsp_valid_o=1; response fields are held stable until rsp_ready_i=1.
  - On handshake: go to IDLE and clear the counter.
  - No pipelining: req_ready_o=0 in SETUP, ACCESS and RESP, so at most one outstanding transfer.
- PADDR, PWDATA and PWRITE are held constant from SETUP through the last ACCESS cycle. They keep their last value in IDLE; they are not zeroed.
- Minimum latency, zero-wait slave with rsp_ready_i=1:
  - accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid_o at 3.
  - req_ready_o returns to 1 at cycle 4, giving 4 cycles per transfer.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates; it never wraps.

Decomposition:
- Shared package apb_pkg:
  - typedef enum apb_master_state_e {IDLE, SETUP, ACCESS, RESP}.
  - localparam APB_ALIGN_BITS=2.
  - typedef struct apb_rsp_t {rdata, err, timeout}.
- One sub-module: apb_timeout_cnt, a parameterized saturating counter with clear, enable and expire outputs. It is tied off when TIMEOUT_CYCLES=0.

Test Plan:
- Write addr 0x0000_0404, data 0xDEADBEEF, zero-wait slave -> PSEL rises cycle 1, PENABLE cycle 2; PADDR=0x404 and PWDATA=0xDEADBEEF stable throughout; rsp_valid at cycle 3 with err=0, rdata=0.
- Read addr 0x0000_0008, slave inserts 3 wait states, PRDATA=0x1234_5678 -> ACCESS lasts 4 cycles; rsp_rdata_o=0x12345678, err=0; PSEL/PENABLE low after completion.
- Read with PSLVERR=1 at PREADY -> rsp_err_o=1, rsp_timeout_o=0, rsp_rdata_o=0.
- Misaligned request addr 0x0000_0002 -> no PSEL assertion ever; rsp_valid at cycle 1 with err=1, timeout=0.
- TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 ACCESS cycles; rsp_err_o=1, rsp_timeout_o=1. Repeat with PREADY=1 on the 4th cycle -> normal completion, err=0.
- Backpressure and reset:
  - rsp_ready_i=0 for 5 cycles -> response stable, req_ready_o=0; next request is accepted only after the handshake.
  - rst_i asserted in ACCESS -> next cycle PSEL=0, PENABLE=0, rsp_valid_o=0, req_ready_o=1.
